maquina_scheduler: RTL and testbench

Round-robin scheduler that shares one `maquina_maluca` machine between `N_REQ` order panels. It latches order requests, grants the machine to one panel at a time, and issues a single-cycle `start` to the machine. It then tracks the machine's `state` output to detect when the machine accepts the order and when it finishes. It sits directly in front of `maquina_maluca`: `mach_start` drives the machine's `start` input, and the machine's `state` output feeds back into `mach_state`.

---
 rtl/maquina_scheduler.sv | 173 +++++++++++++++++
 tb/tb_maquina_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/maquina_scheduler.sv
// Round-robin arbiter that shares one maquina_maluca machine between N_REQ order panels.
// Issues a one-cycle start, then follows the machine state to detect acceptance and completion.
module maquina_scheduler #(
    parameter int unsigned N_REQ         = 4,
    parameter logic [3:0]  IDLE_CODE     = 4'd0,
    parameter int unsigned START_TIMEOUT = 8,
    parameter int unsigned RUN_TIMEOUT   = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [3:0]       mach_state,
    output logic             mach_start,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] pending,
    output logic             err,
    output logic             fault,
    output logic             busy,
    output logic [2:0]       sched_state
);

    localparam int unsigned MaxTo = (START_TIMEOUT > RUN_TIMEOUT) ? START_TIMEOUT : RUN_TIMEOUT;
    localparam int unsigned CntW  = $clog2(MaxTo + 1);
    localparam int unsigned IdxW  = $clog2(N_REQ);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStart    = 3'd1,
        StWaitBusy = 3'd2,
        StWaitDone = 3'd3,
        StFault    = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [IdxW-1:0]  ptr_q, ptr_d;
    logic [IdxW-1:0]  win_q, win_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic             err_q, err_d;
    logic             fault_q, fault_d;
    logic             busy_q, busy_d;
    logic             mach_start_q, mach_start_d;

    logic             win_found;
    logic [IdxW-1:0]  win_idx;
    logic [IdxW-1:0]  cand;
    logic [N_REQ-1:0] clr;
    logic [CntW-1:0]  cnt_inc;

    // Scan from lowest to highest priority so the last hit (pointer+1 side) wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            cand = IdxW'((32'(ptr_q) + N_REQ - 32'(k)) % N_REQ);
            if (pending_q[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign cnt_inc = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + CntW'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        fault_d = fault_q;
        done_d  = '0;
        err_d   = 1'b0;
        clr     = '0;

        case (state_q)
            StIdle: begin
                if (win_found) begin
                    win_d          = win_idx;
                    grant_d        = '0;
                    grant_d[win_idx] = 1'b1;
                    state_d        = StStart;
                end
            end
            StStart: begin
                clr[win_q] = 1'b1;
                ptr_d      = win_q;
                cnt_d      = '0;
                state_d    = StWaitBusy;
            end
            StWaitBusy: begin
                if (mach_state != IDLE_CODE) begin
                    cnt_d   = '0;
                    state_d = StWaitDone;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CntW'(START_TIMEOUT)) begin
                        err_d   = 1'b1;
                        grant_d = '0;
                        state_d = StIdle;
                    end
                end
            end
            StWaitDone: begin
                if (mach_state == IDLE_CODE) begin
                    done_d[win_q] = 1'b1;
                    grant_d       = '0;
                    state_d       = StIdle;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CntW'(RUN_TIMEOUT)) begin
                        fault_d = 1'b1;
                        grant_d = '0;
                        state_d = StFault;
                    end
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A request on the same edge as the clear re-queues the panel.
        pending_d    = (pending_q & ~clr) | req;
        mach_start_d = (state_d == StStart);
        busy_d       = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            ptr_q        <= IdxW'(N_REQ - 1);
            win_q        <= '0;
            cnt_q        <= '0;
            grant_q      <= '0;
            done_q       <= '0;
            pending_q    <= '0;
            err_q        <= 1'b0;
            fault_q      <= 1'b0;
            busy_q       <= 1'b0;
            mach_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            win_q        <= win_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            pending_q    <= pending_d;
            err_q        <= err_d;
            fault_q      <= fault_d;
            busy_q       <= busy_d;
            mach_start_q <= mach_start_d;
        end
    end

    assign mach_start  = mach_start_q;
    assign grant       = grant_q;
    assign done        = done_q;
    assign pending     = pending_q;
    assign err         = err_q;
    assign fault       = fault_q;
    assign busy        = busy_q;
    assign sched_state = state_q;

endmodule

// File: tb/tb_maquina_scheduler.sv
// Bench for maquina_scheduler: reference model of the service rules checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_maquina_scheduler;

    localparam int N = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = '0;
    logic [3:0] mach_state;
    logic       mach_start;
    logic [3:0] grant, done, pending;
    logic       err, fault, busy;
    logic [2:0] sched_state;

    int n_pass  = 0;
    int n_total = 0;
    int mmode   = 0;  // 0: normal run, 1: never leaves idle, 2: never returns to idle
    int mrun    = 0;

    maquina_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .mach_state (mach_state),
        .mach_start (mach_start),
        .grant      (grant),
        .done       (done),
        .pending    (pending),
        .err        (err),
        .fault      (fault),
        .busy       (busy),
        .sched_state(sched_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exhausted");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    endtask

    // Machine stand-in: accepts a start one edge later and runs for 10 cycles.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mach_state <= 4'd0;
            mrun       <= 0;
        end else if (mach_start && mmode != 1) begin
            mach_state <= 4'd5;
            mrun       <= 0;
        end else if (mach_state != 4'd0) begin
            mrun <= mrun + 1;
            if (mmode == 0 && mrun == 9) mach_state <= 4'd0;
        end
    end

    // Reference model: phase 0 idle, 1 start, 2 awaiting acceptance, 3 running, 4 fault.
    int         m_phase  = 0;
    int         m_served = -1;
    int         m_last   = N - 1;
    int         m_age    = 0;
    logic [3:0] m_pend   = '0;
    logic [3:0] m_done   = '0;
    logic [3:0] m_grant  = '0;
    logic [3:0] m_clr    = '0;
    logic       m_err    = 1'b0;
    logic       m_fault  = 1'b0;
    logic       m_start  = 1'b0;

    function automatic int next_panel(input logic [3:0] p, input int last);
        for (int k = 1; k <= N; k++) begin
            if (p[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = 0; m_served = -1; m_last = N - 1; m_age = 0;
            m_pend = '0; m_done = '0; m_err = 1'b0; m_fault = 1'b0; m_start = 1'b0;
        end else begin
            m_clr = '0; m_done = '0; m_err = 1'b0; m_start = 1'b0;
            case (m_phase)
                0: if (m_pend != 0) begin
                    m_served = next_panel(m_pend, m_last);
                    m_phase  = 1;
                    m_start  = 1'b1;
                end
                1: begin
                    m_clr[m_served] = 1'b1;
                    m_last  = m_served;
                    m_age   = 0;
                    m_phase = 2;
                end
                2: if (mach_state != 4'd0) begin
                    m_age = 0; m_phase = 3;
                end else begin
                    m_age++;
                    if (m_age == 8) begin m_err = 1'b1; m_served = -1; m_phase = 0; end
                end
                3: if (mach_state == 4'd0) begin
                    m_done[m_served] = 1'b1; m_served = -1; m_phase = 0;
                end else begin
                    m_age++;
                    if (m_age == 255) begin m_fault = 1'b1; m_served = -1; m_phase = 4; end
                end
                default: ;
            endcase
            m_pend = (m_pend & ~m_clr) | req;
        end
        m_grant = (m_served >= 0) ? 4'(1 << m_served) : 4'd0;
    end

    always begin
        @(posedge clk);
        #1;
        check("cycle_model",
              {13'd0, mach_start, grant, done, pending, err, fault, busy, sched_state},
              {13'd0, m_start, m_grant, m_done, m_pend, m_err, m_fault, (m_phase != 0),
               3'(m_phase)});
    end

    localparam int WDone = 0, WErr = 1, WFault = 2, WState = 10;

    function automatic logic cond(input int w);
        case (w)
            WDone:   return done != 0;
            WErr:    return err;
            WFault:  return fault;
            default: return sched_state == 3'(w - WState);
        endcase
    endfunction

    task automatic wait_for(input int w, input int budget, output int cyc);
        cyc = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (cond(w)) return;
        end
        check($sformatf("wait_timeout_%0d", w), 32'(cond(w)), 1);
    endtask

    logic [3:0] got[$];

    task automatic collect(input int n, input int budget);
        got.delete();
        for (int c = 0; c < budget && got.size() < n; c++) begin
            @(negedge clk);
            if (sched_state == 3'd1) got.push_back(grant);
        end
    endtask

    task automatic pulse_req(input logic [3:0] v);
        req = v;
        @(negedge clk);
        req = '0;
    endtask

    initial begin
        int         c;
        logic       found;
        logic [3:0] exp_rr[4];
        exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_outputs",
              {mach_start, grant, done, pending, err, fault, busy, sched_state}, 0);

        // Single request and full service on panel 1
        pulse_req(4'b0010);
        check("pending_after_e0", pending, 4'b0010);
        @(negedge clk);
        check("grant_after_e1", grant, 4'b0010);
        check("start_after_e1", mach_start, 1);
        @(negedge clk);
        check("start_one_cycle", mach_start, 0);
        check("wait_busy_after_e2", sched_state, 2);
        check("pending_cleared_e2", pending, 0);
        wait_for(WDone, 40, c);
        check("done_panel1", done, 4'b0010);
        @(negedge clk);
        check("idle_after_done", {grant, pending, busy}, 0);

        // Round robin from a fresh pointer
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        pulse_req(4'b1111);
        collect(4, 200);
        check("rr_count", got.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("rr_grant_%0d", i), got[i], exp_rr[i]);
        wait_for(WState + 0, 40, c);
        pulse_req(4'b1001);
        collect(2, 100);
        check("rr2_count", got.size(), 2);
        check("rr2_first", got[0], 4'b0001);
        check("rr2_second", got[1], 4'b1000);
        wait_for(WState + 0, 40, c);

        // Start timeout: machine never leaves idle
        mmode = 1;
        pulse_req(4'b0110);
        wait_for(WState + 2, 20, c);
        check("to_first_grant", grant, 4'b0010);
        wait_for(WErr, 20, c);
        check("err_latency", c, 8);
        check("to_no_done", done, 0);
        check("to_back_idle", sched_state, 0);
        wait_for(WState + 1, 10, c);
        check("to_next_grant", grant, 4'b0100);
        wait_for(WErr, 20, c);
        @(negedge clk);
        check("to_final_idle", {sched_state, pending}, 0);

        // Run timeout: machine never returns to idle
        mmode = 2;
        pulse_req(4'b0001);
        wait_for(WState + 3, 20, c);
        wait_for(WFault, 300, c);
        check("fault_latency", c, 255);
        check("fault_state", {sched_state, busy, grant}, {3'd4, 1'b1, 4'd0});
        pulse_req(4'b1000);
        repeat (5) @(negedge clk);
        check("fault_pending", pending, 4'b1000);
        check("fault_no_grant", {grant, sched_state}, {4'd0, 3'd4});
        reset = 1'b0;
        #1;
        check("fault_reset", {mach_start, grant, done, pending, err, fault, busy, sched_state}, 0);
        @(negedge clk);
        reset = 1'b1;

        // Reset in the middle of a run, then re-queue on the done edge
        mmode = 0;
        pulse_req(4'b0100);
        wait_for(WState + 3, 20, c);
        pulse_req(4'b0001);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrun_reset", {grant, pending, mach_start, sched_state}, 0);
        @(negedge clk);
        reset = 1'b1;
        pulse_req(4'b0100);
        wait_for(WState + 3, 20, c);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mach_state == 4'd0 && sched_state == 3'd3) begin
                found = 1'b1;
                pulse_req(4'b0100);
            end else begin
                @(negedge clk);
            end
        end
        check("requeue_window", found, 1);
        check("requeue_done", done, 4'b0100);
        check("requeue_pending", pending, 4'b0100);
        wait_for(WState + 1, 10, c);
        check("requeue_grant", grant, 4'b0100);
        wait_for(WDone, 40, c);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
